// File: rtl/mips_intctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_intctrl_if
// Brief    : Device request lines and register-window bus for mips_intctrl.
// Revision : 1.0
// ============================================================================
interface mips_intctrl_if #(
    parameter int NSRC = 8
);
    logic [NSRC-1:0] IRQ;
    logic [4:0]      Addr;
    logic            WE;
    logic [31:0]     Din;
    logic [31:0]     Dout;
    logic            HWIntOut;

    modport master (
        output IRQ, Addr, WE, Din,
        input  Dout, HWIntOut
    );

    modport slave (
        input  IRQ, Addr, WE, Din,
        output Dout, HWIntOut
    );
endinterface
`default_nettype wire

// File: rtl/mips_intctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_intctrl
// Brief    : Fixed-priority interrupt controller with claim/EOI handshake
//            driving one CP0 hardware-interrupt line.
// Revision : 1.0
// ============================================================================
module mips_intctrl #(
    parameter int NSRC = 8
) (
    input  logic          clk,
    input  logic          reset,
    mips_intctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SVC  = 2'd2
    } state_t;

    localparam logic [2:0] c_OFF_PEND  = 3'd0;
    localparam logic [2:0] c_OFF_MASK  = 3'd1;
    localparam logic [2:0] c_OFF_MODE  = 3'd2;
    localparam logic [2:0] c_OFF_CLAIM = 3'd3;
    localparam logic [2:0] c_OFF_EOI   = 3'd4;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NSRC-1:0] r_sync1;
    logic [NSRC-1:0] r_sync2;
    logic [NSRC-1:0] r_sync_d;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_mode;
    logic [NSRC-1:0] r_epend;
    logic [4:0]      r_svc_id;

    logic [2:0]      w_off;
    logic            w_wr_pend;
    logic            w_wr_mask;
    logic            w_wr_mode;
    logic            w_wr_claim;
    logic            w_wr_eoi;
    logic            w_claim;
    logic [NSRC-1:0] w_pend;
    logic [NSRC-1:0] w_active;
    logic [NSRC-1:0] w_set;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_claim_clr;
    logic [4:0]      w_cur_id;
    logic [31:0]     w_claim_rd;
    logic            w_unused;

    assign w_unused   = &{1'b0, bus.Addr[1:0], bus.Din};

    assign w_off      = bus.Addr[4:2];
    assign w_wr_pend  = bus.WE && (w_off == c_OFF_PEND);
    assign w_wr_mask  = bus.WE && (w_off == c_OFF_MASK);
    assign w_wr_mode  = bus.WE && (w_off == c_OFF_MODE);
    assign w_wr_claim = bus.WE && (w_off == c_OFF_CLAIM);
    assign w_wr_eoi   = bus.WE && (w_off == c_OFF_EOI);

    // Level sources report the synchronized line directly; edge sources the latch.
    assign w_pend   = (r_epend & r_mode) | (r_sync2 & ~r_mode);
    assign w_active = w_pend & r_mask;

    always_comb begin
        w_cur_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_active[i]) w_cur_id = 5'(i);
        end
    end

    assign w_claim     = w_wr_claim && (r_state == S_REQ) && (|w_active);
    assign w_claim_clr = w_claim ? (NSRC'(1) << w_cur_id) : '0;
    assign w_set       = r_sync2 & ~r_sync_d & r_mode;
    assign w_clr       = (w_wr_pend ? bus.Din[NSRC-1:0] : '0) | w_claim_clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync_d <= '0;
            r_mask   <= '0;
            r_mode   <= '0;
            r_epend  <= '0;
            r_svc_id <= '0;
        end else begin
            r_sync1  <= bus.IRQ;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            if (w_wr_mask) r_mask <= bus.Din[NSRC-1:0];
            if (w_wr_mode) r_mode <= bus.Din[NSRC-1:0];
            // A new edge overrides a same-cycle clear; level-mode bits never latch.
            r_epend  <= ((r_epend & ~w_clr) | w_set) & r_mode;
            if (w_claim) r_svc_id <= w_cur_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (|w_active) w_state_nxt = S_REQ;
            S_REQ: begin
                if (!(|w_active)) w_state_nxt = S_IDLE;
                else if (w_claim) w_state_nxt = S_SVC;
            end
            S_SVC:  if (w_wr_eoi) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_claim_rd = '0;
        case (r_state)
            S_REQ: w_claim_rd = {1'b1, 1'b0, 25'd0, w_cur_id};
            S_SVC: w_claim_rd = {1'b0, 1'b1, 25'd0, r_svc_id};
            default: w_claim_rd = '0;
        endcase
    end

    always_comb begin
        bus.Dout = '0;
        case (w_off)
            c_OFF_PEND:  bus.Dout = 32'(w_pend);
            c_OFF_MASK:  bus.Dout = 32'(r_mask);
            c_OFF_MODE:  bus.Dout = 32'(r_mode);
            c_OFF_CLAIM: bus.Dout = w_claim_rd;
            default:     bus.Dout = '0;
        endcase
    end

    assign bus.HWIntOut = (r_state == S_REQ);
endmodule
`default_nettype wire

// File: tb/tb_mips_intctrl.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module   : tb_mips_intctrl
// Brief    : Vector-table bench for mips_intctrl with an expected-value queue.
// Revision : 1.0
// ============================================================================
module tb_mips_intctrl;
    localparam int NSRC = 8;

    typedef struct {
        logic [NSRC-1:0] irq;
        logic            we;
        logic [4:0]      addr;
        logic [31:0]     din;
        logic [31:0]     dout;
        logic            hwint;
    } vec_t;

    typedef struct {
        logic [31:0] dout;
        logic        hwint;
        int          idx;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    mips_intctrl_if #(.NSRC(NSRC)) bus ();

    mips_intctrl #(.NSRC(NSRC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    vec_t tbl[$];
    exp_t sb[$];
    int   nvec = 0;
    int   nmis = 0;
    int   n_pre;

    task automatic v(input logic [31:0] irq, input logic [31:0] we, input logic [31:0] addr,
                     input logic [31:0] din, input logic [31:0] dout, input logic [31:0] hwint);
        vec_t t;
        t.irq   = irq[NSRC-1:0];
        t.we    = we[0];
        t.addr  = addr[4:0];
        t.din   = din;
        t.dout  = dout;
        t.hwint = hwint[0];
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic apply(input int i);
        exp_t e;
        @(negedge clk);
        bus.IRQ  = tbl[i].irq;
        bus.WE   = tbl[i].we;
        bus.Addr = tbl[i].addr;
        bus.Din  = tbl[i].din;
        e.dout   = tbl[i].dout;
        e.hwint  = tbl[i].hwint;
        e.idx    = i;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("vec%0d dout", e.idx), bus.Dout, e.dout);
        chk($sformatf("vec%0d hwint", e.idx), 32'(bus.HWIntOut), 32'(e.hwint));
    endtask

    initial begin
        // irq, we, addr, din, expected Dout after the edge, expected HWIntOut
        v(0, 0, 'h00, 0, 0, 0);
        v(0, 0, 'h04, 0, 0, 0);
        v(0, 0, 'h08, 0, 0, 0);
        v(0, 0, 'h0C, 0, 0, 0);
        v(0, 0, 'h10, 0, 0, 0);
        v(0, 1, 'h14, 'hFFFFFFFF, 0, 0);
        // edge-mode claim / EOI on source 3
        v(0, 1, 'h04, 'h08, 'h08, 0);
        v(0, 1, 'h08, 'h08, 'h08, 0);
        v('h08, 0, 'h0C, 0, 0, 0);
        v('h08, 0, 'h00, 0, 0, 0);
        v('h08, 0, 'h00, 0, 'h08, 0);
        v(0, 0, 'h0C, 0, 'h80000003, 1);
        v(0, 1, 'h0C, 0, 'h40000003, 0);
        v(0, 0, 'h00, 0, 0, 0);
        v(0, 1, 'h10, 0, 0, 0);
        v(0, 0, 'h0F, 0, 0, 0);
        // level priority and re-request
        v('h24, 1, 'h08, 0, 0, 0);
        v('h24, 1, 'h04, 'hFF, 'hFF, 0);
        v('h24, 0, 'h0C, 0, 'h80000002, 1);
        v('h24, 1, 'h0C, 0, 'h40000002, 0);
        v('h24, 1, 'h10, 0, 0, 0);
        v('h24, 0, 'h0E, 0, 'h80000002, 1);
        v('h20, 0, 'h0C, 0, 'h80000002, 1);
        v('h20, 0, 'h0C, 0, 'h80000005, 1);
        v('h20, 1, 'h0C, 0, 'h40000005, 0);
        v(0, 1, 'h04, 0, 0, 0);
        v(0, 0, 'h0C, 0, 'h40000005, 0);
        v(0, 1, 'h10, 0, 0, 0);
        v(0, 0, 'h0C, 0, 0, 0);
        v(0, 1, 'h0C, 0, 0, 0);
        // masking, then W1C withdrawal from REQ
        v('h02, 1, 'h08, 'h02, 'h02, 0);
        v('h02, 0, 'h00, 0, 0, 0);
        v('h02, 0, 'h00, 0, 'h02, 0);
        v(0, 0, 'h0C, 0, 0, 0);
        v(0, 1, 'h04, 'h02, 'h02, 0);
        v(0, 0, 'h0C, 0, 'h80000001, 1);
        v(0, 1, 'h00, 'h02, 0, 1);
        v(0, 0, 'h0C, 0, 0, 0);
        // set/clear collision on source 1, then into SVC
        v('h02, 0, 'h00, 0, 0, 0);
        v('h02, 0, 'h00, 0, 0, 0);
        v('h02, 1, 'h00, 'h02, 'h02, 0);
        v(0, 0, 'h0C, 0, 'h80000001, 1);
        v(0, 1, 'h0C, 0, 'h40000001, 0);
        v(0, 1, 'h04, 'hFFFFFFFF, 'hFF, 0);
        n_pre = tbl.size();
        // after asynchronous reset: edge pulse on source 0
        v(0, 1, 'h08, 'h01, 'h01, 0);
        v(0, 1, 'h04, 'h01, 'h01, 0);
        v('h01, 0, 'h0C, 0, 0, 0);
        v('h01, 0, 'h0C, 0, 0, 0);
        v('h01, 0, 'h00, 0, 'h01, 0);
        v(0, 0, 'h0C, 0, 'h80000000, 1);

        reset    = 1'b1;
        bus.IRQ  = '0;
        bus.WE   = 1'b0;
        bus.Addr = '0;
        bus.Din  = '0;
        #12;
        chk("reset hwint", 32'(bus.HWIntOut), 0);
        chk("reset pend", bus.Dout, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < n_pre; i++) apply(i);

        // Mid-cycle reset while in SVC: everything must clear before any edge.
        @(negedge clk);
        bus.WE = 1'b0;
        #1 reset = 1'b1;
        #0.5;
        chk("async hwint", 32'(bus.HWIntOut), 0);
        for (int a = 0; a < 5; a++) begin
            bus.Addr = 5'(a * 4);
            #0.5;
            chk($sformatf("async rd %02h", a * 4), bus.Dout, 0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = n_pre; i < tbl.size(); i++) apply(i);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
`default_nettype wire
